// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous memory.
// Each granted op runs IDLE -> ISSUE -> WAIT -> RESP; an out-of-range address goes straight to RESP.
module mem_arbiter #(
   parameter int DW    = 24,
   parameter int AW    = 8,
   parameter int DEPTH = 128
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   output logic          f_ack,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] rdata,
   output logic          err,
   output logic          busy,
   output logic [AW-1:0] mem_mar,
   output logic [DW-1:0] mem_data_in,
   output logic          mem_en,
   output logic          mem_cs,
   input  logic [DW-1:0] mem_data_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [AW:0] DepthLimit = DEPTH[AW:0];

   state_t        state_q, state_d;
   logic          ptr_q, ptr_d;
   logic          gnt_q, gnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          we_q, we_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          f_ack_q, f_ack_d;
   logic          d_ack_q, d_ack_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          err_q, err_d;
   logic          busy_q, busy_d;
   logic [AW-1:0] mem_mar_q, mem_mar_d;
   logic [DW-1:0] mem_data_in_q, mem_data_in_d;
   logic          mem_en_q, mem_en_d;
   logic          mem_cs_q, mem_cs_d;
   logic          pickData;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ptr_q         <= 1'b0;
         gnt_q         <= 1'b0;
         addr_q        <= '0;
         we_q          <= 1'b0;
         wdata_q       <= '0;
         f_ack_q       <= 1'b0;
         d_ack_q       <= 1'b0;
         rdata_q       <= '0;
         err_q         <= 1'b0;
         busy_q        <= 1'b0;
         mem_mar_q     <= '0;
         mem_data_in_q <= '0;
         mem_en_q      <= 1'b0;
         mem_cs_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         gnt_q         <= gnt_d;
         addr_q        <= addr_d;
         we_q          <= we_d;
         wdata_q       <= wdata_d;
         f_ack_q       <= f_ack_d;
         d_ack_q       <= d_ack_d;
         rdata_q       <= rdata_d;
         err_q         <= err_d;
         busy_q        <= busy_d;
         mem_mar_q     <= mem_mar_d;
         mem_data_in_q <= mem_data_in_d;
         mem_en_q      <= mem_en_d;
         mem_cs_q      <= mem_cs_d;
      end
   end

   // Outputs are computed for the state being entered, so every output comes straight from a flop.
   // ptr_q high means data wins the next tie; gnt_q remembers who owns the op in flight.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      gnt_d         = gnt_q;
      addr_d        = addr_q;
      we_d          = we_q;
      wdata_d       = wdata_q;
      f_ack_d       = 1'b0;
      d_ack_d       = 1'b0;
      rdata_d       = rdata_q;
      err_d         = err_q;
      mem_mar_d     = '0;
      mem_data_in_d = '0;
      mem_en_d      = 1'b0;
      mem_cs_d      = 1'b0;
      pickData      = 1'b0;

      case (state_q)
         IDLE: begin
            if (f_req || d_req) begin
               pickData = d_req && (!f_req || ptr_q);
               gnt_d    = pickData;
               ptr_d    = !pickData;
               addr_d   = pickData ? d_addr : f_addr;
               we_d     = pickData ? d_we : 1'b0;
               wdata_d  = pickData ? d_wdata : '0;
               if ({1'b0, addr_d} >= DepthLimit) begin
                  state_d = RESP;
                  f_ack_d = !pickData;
                  d_ack_d = pickData;
                  rdata_d = '0;
                  err_d   = 1'b1;
               end else begin
                  state_d       = ISSUE;
                  mem_en_d      = 1'b1;
                  mem_cs_d      = we_d;
                  mem_mar_d     = addr_d;
                  mem_data_in_d = wdata_d;
               end
            end
         end
         ISSUE: begin
            state_d = WAIT;
         end
         WAIT: begin
            state_d = RESP;
            f_ack_d = !gnt_q;
            d_ack_d = gnt_q;
            rdata_d = we_q ? '0 : mem_data_out;
            err_d   = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign f_ack       = f_ack_q;
   assign d_ack       = d_ack_q;
   assign rdata       = rdata_q;
   assign err         = err_q;
   assign busy        = busy_q;
   assign mem_mar     = mem_mar_q;
   assign mem_data_in = mem_data_in_q;
   assign mem_en      = mem_en_q;
   assign mem_cs      = mem_cs_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural memory answers the arbiter, and every
// expected value below is worked out by hand from the request timeline.
module tb_mem_arbiter;

   localparam int DW    = 24;
   localparam int AW    = 8;
   localparam int DEPTH = 128;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          f_req;
   logic [AW-1:0] f_addr;
   logic          f_ack;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_ack;
   logic [DW-1:0] rdata;
   logic          err;
   logic          busy;
   logic [AW-1:0] mem_mar;
   logic [DW-1:0] mem_data_in;
   logic          mem_en;
   logic          mem_cs;
   logic [DW-1:0] mem_data_out;

   logic [DW-1:0] memArray [DEPTH];
   int            vectors = 0;
   int            miscompares = 0;

   mem_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .f_req        (f_req),
      .f_addr       (f_addr),
      .f_ack        (f_ack),
      .d_req        (d_req),
      .d_we         (d_we),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_ack        (d_ack),
      .rdata        (rdata),
      .err          (err),
      .busy         (busy),
      .mem_mar      (mem_mar),
      .mem_data_in  (mem_data_in),
      .mem_en       (mem_en),
      .mem_cs       (mem_cs),
      .mem_data_out (mem_data_out)
   );

   always #5 clk = ~clk;

   // Single-port memory: acts on the edge where EN is high, read data registered.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_cs) memArray[mem_mar[6:0]] <= mem_data_in;
         else        mem_data_out <= memArray[mem_mar[6:0]];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic fReq, input logic [AW-1:0] fAddr, input logic dReq,
                                input logic dWe, input logic [AW-1:0] dAddr, input logic [DW-1:0] dWdata);
      f_req   = fReq;
      f_addr  = fAddr;
      d_req   = dReq;
      d_we    = dWe;
      d_addr  = dAddr;
      d_wdata = dWdata;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) memArray[i] = '0;
      memArray[20] = 24'h031E00;
      mem_data_out = '0;
      rst_n = 1'b0;
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 24'd0);
      tick();
      tick();
      rst_n = 1'b1;

      checkOutput("reset busy",   32'(busy),   0);
      checkOutput("reset f_ack",  32'(f_ack),  0);
      checkOutput("reset d_ack",  32'(d_ack),  0);
      checkOutput("reset rdata",  32'(rdata),  0);
      checkOutput("reset err",    32'(err),    0);
      checkOutput("reset mem_en", 32'(mem_en), 0);

      // Fetch read of cell 20; the address is changed after grant and must not matter.
      applyStimulus(1'b1, 8'd20, 1'b0, 1'b0, 8'd0, 24'd0);
      tick();
      checkOutput("fetch issue en",  32'(mem_en),  1);
      checkOutput("fetch issue cs",  32'(mem_cs),  0);
      checkOutput("fetch issue mar", 32'(mem_mar), 20);
      checkOutput("fetch issue busy", 32'(busy),   1);
      checkOutput("fetch issue ack", 32'(f_ack),   0);
      f_addr = 8'd21;
      tick();
      checkOutput("fetch wait en",  32'(mem_en), 0);
      checkOutput("fetch wait ack", 32'(f_ack),  0);
      tick();
      checkOutput("fetch resp f_ack", 32'(f_ack), 1);
      checkOutput("fetch resp d_ack", 32'(d_ack), 0);
      checkOutput("fetch resp rdata", 32'(rdata), 32'h031E00);
      checkOutput("fetch resp err",   32'(err),   0);
      f_req = 1'b0;
      tick();
      checkOutput("fetch done ack",  32'(f_ack), 0);
      checkOutput("fetch done busy", 32'(busy),  0);
      checkOutput("fetch hold rdata", 32'(rdata), 32'h031E00);

      // Data write 9 to cell 31; wdata changes after grant.
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 8'd31, 24'd9);
      tick();
      checkOutput("write issue en",  32'(mem_en),      1);
      checkOutput("write issue cs",  32'(mem_cs),      1);
      checkOutput("write issue mar", 32'(mem_mar),     31);
      checkOutput("write issue din", 32'(mem_data_in), 9);
      d_wdata = 24'd77;
      tick();
      tick();
      checkOutput("write resp d_ack", 32'(d_ack), 1);
      checkOutput("write resp rdata", 32'(rdata), 0);
      checkOutput("write resp err",   32'(err),   0);
      d_req = 1'b0;
      tick();

      // Read cell 31 back.
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd31, 24'd0);
      tick();
      checkOutput("read issue en", 32'(mem_en), 1);
      checkOutput("read issue cs", 32'(mem_cs), 0);
      tick();
      checkOutput("read wait ack", 32'(d_ack), 0);
      tick();
      checkOutput("read resp d_ack", 32'(d_ack), 1);
      checkOutput("read resp rdata", 32'(rdata), 9);
      d_req = 1'b0;
      tick();
      checkOutput("read done ack", 32'(d_ack), 0);

      // Out-of-range fetch: ack after one edge, memory untouched.
      applyStimulus(1'b1, 8'd200, 1'b0, 1'b0, 8'd0, 24'd0);
      tick();
      checkOutput("oor f_ack",  32'(f_ack),  1);
      checkOutput("oor err",    32'(err),    1);
      checkOutput("oor rdata",  32'(rdata),  0);
      checkOutput("oor mem_en", 32'(mem_en), 0);
      f_req = 1'b0;
      tick();
      checkOutput("oor done ack",  32'(f_ack),  0);
      checkOutput("oor hold err",  32'(err),    1);
      checkOutput("oor done en",   32'(mem_en), 0);
      checkOutput("oor done busy", 32'(busy),   0);

      // Contention from reset release: the last grant was fetch, so only a pointer
      // reset makes fetch win first. Grants at edges 0,4,8,12 alternate F,D,F,D.
      rst_n = 1'b0;
      applyStimulus(1'b1, 8'd20, 1'b1, 1'b0, 8'd31, 24'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         checkOutput($sformatf("contend f_ack %0d", i), 32'(f_ack), 32'((i % 8) == 2));
         checkOutput($sformatf("contend d_ack %0d", i), 32'(d_ack), 32'((i % 8) == 6));
         if ((i % 8) == 2) checkOutput($sformatf("contend f rdata %0d", i), 32'(rdata), 32'h031E00);
         if ((i % 8) == 6) checkOutput($sformatf("contend d rdata %0d", i), 32'(rdata), 9);
      end

      // Reset during the WAIT cycle of a data read.
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 24'd0);
      tick();
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd31, 24'd0);
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      checkOutput("abort busy",  32'(busy),    0);
      checkOutput("abort d_ack", 32'(d_ack),   0);
      checkOutput("abort rdata", 32'(rdata),   0);
      checkOutput("abort err",   32'(err),     0);
      checkOutput("abort en",    32'(mem_en),  0);
      checkOutput("abort mar",   32'(mem_mar), 0);
      rst_n = 1'b1;
      f_req  = 1'b1;
      f_addr = 8'd20;
      tick();
      checkOutput("post-abort grant mar", 32'(mem_mar), 20);
      checkOutput("post-abort grant en",  32'(mem_en),  1);
      tick();
      checkOutput("post-abort no d_ack", 32'(d_ack), 0);
      tick();
      checkOutput("post-abort f_ack", 32'(f_ack), 1);
      checkOutput("post-abort d_ack", 32'(d_ack), 0);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 24'd0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Protocol invariants checked every cycle away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (f_ack && d_ack) checkOutput("dual ack", 32'({f_ack, d_ack}), 32'b10);
         if (mem_en && !busy) checkOutput("mem_en while idle", 32'(mem_en), 0);
      end
   end

endmodule
